// File: rtl/gate_mux_bist_pkg.sv
// Shared types and constants for the gate-library stimulus/check engine.
package gate_mux_bist_pkg;

    // Sequencer states: wait for a request, hold a vector, compare the responses.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2
    } bist_state_t;

    localparam int NUM_GATES = 7;
    localparam int NUM_VECS  = 4;

    // Bit positions of each gate inside resp / fail_mask.
    localparam int AND_IDX  = 0;
    localparam int OR_IDX   = 1;
    localparam int NOR_IDX  = 2;
    localparam int NAND_IDX = 3;
    localparam int NOT_IDX  = 4;
    localparam int XOR_IDX  = 5;
    localparam int XNOR_IDX = 6;

    // {A,B} of the final vector in the sweep.
    localparam logic [1:0] LAST_VEC = 2'(NUM_VECS - 1);

endpackage : gate_mux_bist_pkg

// File: rtl/gate_golden_model.sv
// Combinational reference outputs of the seven library gates for one {A,B} vector.
module gate_golden_model
    import gate_mux_bist_pkg::*;
(
    input  logic [1:0]           vec,
    output logic [NUM_GATES-1:0] expected
);

    logic a_s;
    logic b_s;

    // Evaluate every gate function for the vector, A being the MSB.
    always_comb begin
        expected           = {NUM_GATES{1'b0}};
        a_s                = vec[1];
        b_s                = vec[0];
        expected[AND_IDX]  = a_s & b_s;
        expected[OR_IDX]   = a_s | b_s;
        expected[NOR_IDX]  = ~(a_s | b_s);
        expected[NAND_IDX] = ~(a_s & b_s);
        expected[NOT_IDX]  = ~a_s;
        expected[XOR_IDX]  = a_s ^ b_s;
        expected[XNOR_IDX] = ~(a_s ^ b_s);
    end

endmodule : gate_golden_model

// File: rtl/gate_mux_bist_param_chk.sv
// Elaboration-time legality check of the engine's parameters.
module gate_mux_bist_param_chk #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 3
) ();

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("gate_mux_bist: SETTLE_CYCLES=%0d outside 1..15", SETTLE_CYCLES);
    end

    if (ERR_W < 1) begin : g_bad_err_w
        $error("gate_mux_bist: ERR_W=%0d must be at least 1", ERR_W);
    end

endmodule : gate_mux_bist_param_chk

// File: rtl/gate_mux_bist.sv
// Sweeps A/B through 00,01,10,11, holds each vector SETTLE_CYCLES cycles, then
// compares the seven gate responses with the golden model and keeps a sticky summary.
module gate_mux_bist
    import gate_mux_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 A,
    output logic                 B,
    input  logic [NUM_GATES-1:0] resp,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_GATES-1:0] fail_mask,
    output logic [ERR_W-1:0]     err_cnt,
    output logic                 first_fail_valid,
    output logic [1:0]           first_fail_vec
);

    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);

    bist_state_t          state_r;
    logic [1:0]           vec_r;
    logic [1:0]           ab_r;
    logic [3:0]           settle_cnt_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 pass_r;
    logic [NUM_GATES-1:0] fail_mask_r;
    logic [ERR_W-1:0]     err_cnt_r;
    logic                 ff_valid_r;
    logic [1:0]           ff_vec_r;

    logic [NUM_GATES-1:0] golden_s;
    logic [NUM_GATES-1:0] mism_s;
    logic [NUM_GATES-1:0] fail_next_s;
    logic                 any_mism_s;
    logic [ERR_W-1:0]     err_next_s;

    gate_mux_bist_param_chk #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .ERR_W         (ERR_W)
    ) u_param_chk ();

    gate_golden_model u_golden (
        .vec      (vec_r),
        .expected (golden_s)
    );

    // Mismatch of the current vector and the accumulator values it would produce.
    always_comb begin
        mism_s      = resp ^ golden_s;
        fail_next_s = fail_mask_r | mism_s;
        any_mism_s  = |mism_s;
        if (any_mism_s && (err_cnt_r != ERR_MAX)) begin
            err_next_s = err_cnt_r + ERR_ONE;
        end else begin
            err_next_s = err_cnt_r;
        end
    end

    // Sequencer: vector/settle counters, stimulus drive and result accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            vec_r        <= 2'd0;
            ab_r         <= 2'd0;
            settle_cnt_r <= 4'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            fail_mask_r  <= {NUM_GATES{1'b0}};
            err_cnt_r    <= {ERR_W{1'b0}};
            ff_valid_r   <= 1'b0;
            ff_vec_r     <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Results stay visible here until a new run is requested.
                    if (start) begin
                        vec_r        <= 2'd0;
                        ab_r         <= 2'd0;
                        settle_cnt_r <= SETTLE_LOAD;
                        busy_r       <= 1'b1;
                        done_r       <= 1'b0;
                        pass_r       <= 1'b0;
                        fail_mask_r  <= {NUM_GATES{1'b0}};
                        err_cnt_r    <= {ERR_W{1'b0}};
                        ff_valid_r   <= 1'b0;
                        ff_vec_r     <= 2'd0;
                        state_r      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // Counter loaded with SETTLE_CYCLES-1 so this state lasts SETTLE_CYCLES cycles.
                    if (settle_cnt_r == 4'd0) begin
                        state_r <= ST_CHECK;
                    end else begin
                        settle_cnt_r <= settle_cnt_r - 4'd1;
                    end
                end
                ST_CHECK: begin
                    fail_mask_r <= fail_next_s;
                    err_cnt_r   <= err_next_s;
                    if (any_mism_s && !ff_valid_r) begin
                        ff_valid_r <= 1'b1;
                        ff_vec_r   <= vec_r;
                    end
                    if (vec_r != LAST_VEC) begin
                        vec_r        <= vec_r + 2'd1;
                        ab_r         <= vec_r + 2'd1;
                        settle_cnt_r <= SETTLE_LOAD;
                        state_r      <= ST_SETTLE;
                    end else begin
                        vec_r   <= 2'd0;
                        ab_r    <= 2'd0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        pass_r  <= (fail_next_s == {NUM_GATES{1'b0}});
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    vec_r   <= 2'd0;
                    ab_r    <= 2'd0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign A                = ab_r[1];
    assign B                = ab_r[0];
    assign busy             = busy_r;
    assign done             = done_r;
    assign pass             = pass_r;
    assign fail_mask        = fail_mask_r;
    assign err_cnt          = err_cnt_r;
    assign first_fail_valid = ff_valid_r;
    assign first_fail_vec   = ff_vec_r;

endmodule : gate_mux_bist

// File: tb/tb_gate_mux_bist.sv
// Scoreboard bench: a modelled gate library with per-vector fault masks feeds the
// engine; expected summaries are queued at each accepted start and popped on done.
module tb_gate_mux_bist;

    localparam int S   = 2;
    localparam int RUN = 4 * (S + 1);

    // Reference gate functions straight from the truth rules, bit 0 = AND ... bit 6 = XNOR.
    function automatic logic [6:0] gold_f(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~a, ~(a & b), ~(a | b), a | b, a & b};
    endfunction

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       A, B;
    logic [6:0] resp;
    logic       busy, done, pass;
    logic [6:0] fail_mask;
    logic [2:0] err_cnt;
    logic       ffv;
    logic [1:0] ffvec;

    logic       start_s;
    logic       A_s, B_s;
    logic [6:0] resp_s;
    logic       busy_s, done_s, pass_s;
    logic [6:0] fail_mask_s;
    logic [1:0] err_cnt_s;
    logic       ffv_s;
    logic [1:0] ffvec_s;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    logic [6:0] flip_a [4];

    typedef struct {
        int         t0;
        logic [6:0] fm;
        int         err;
        logic       ffv;
        logic [1:0] ffvec;
        logic       pass;
    } exp_t;

    exp_t q[$];
    logic done_q = 1'b0;

    gate_mux_bist #(.SETTLE_CYCLES(S), .ERR_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .resp(resp),
        .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask),
        .err_cnt(err_cnt), .first_fail_valid(ffv), .first_fail_vec(ffvec)
    );

    gate_mux_bist #(.SETTLE_CYCLES(1), .ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start_s), .A(A_s), .B(B_s), .resp(resp_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .fail_mask(fail_mask_s),
        .err_cnt(err_cnt_s), .first_fail_valid(ffv_s), .first_fail_vec(ffvec_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Modelled gate library: correct outputs with the selected faults applied.
    always_comb resp = gold_f(A, B) ^ flip_a[{A, B}];
    always_comb resp_s = ~gold_f(A_s, B_s);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Expected summary of a run from the fault masks: a vector mismatches iff its mask is nonzero.
    task automatic push_expect(input int t0);
        exp_t e;
        e.t0 = t0; e.fm = 7'd0; e.err = 0; e.ffv = 1'b0; e.ffvec = 2'd0;
        for (int v = 0; v < 4; v++) begin
            if (flip_a[v] != 7'd0) begin
                e.fm |= flip_a[v];
                e.err++;
                if (!e.ffv) begin e.ffv = 1'b1; e.ffvec = 2'(v); end
            end
        end
        if (e.err > 7) e.err = 7;
        e.pass = (e.fm == 7'd0);
        q.push_back(e);
    endtask

    task automatic launch(output int t0);
        @(negedge clk);
        start = 1'b1;
        t0 = cyc + 1;
        push_expect(t0);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (q.size() != 0 || busy); i++) @(negedge clk);
        check("drain_timeout", 32'({q.size() != 0, busy}), 32'd0);
        q.delete();
    endtask

    task automatic set_flips(input logic [6:0] f0, input logic [6:0] f1,
                             input logic [6:0] f2, input logic [6:0] f3);
        flip_a[0] = f0; flip_a[1] = f1; flip_a[2] = f2; flip_a[3] = f3;
    endtask

    // Monitor: stimulus sequence while a run is expected, summary compare on each done rise.
    always @(negedge clk) begin
        if (!rst) begin
            if (q.size() > 0) begin
                int k;
                k = cyc - q[0].t0;
                if (k >= 0 && k < RUN)
                    check("run_vec", 32'({busy, A, B}), 32'({1'b1, 2'(k / (S + 1))}));
            end
            if (done && !done_q) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("done_time", 32'(cyc), 32'(e.t0 + RUN));
                    check("fail_mask", 32'(fail_mask), 32'(e.fm));
                    check("err_cnt", 32'(err_cnt), 32'(e.err));
                    check("first_fail", 32'({ffv, ffvec}), 32'({e.ffv, e.ffvec}));
                    check("pass", 32'({pass, busy}), 32'({e.pass, 1'b0}));
                end
            end
        end
        done_q <= done;
    end

    initial begin
        int t0;
        int tb;
        rst = 1'b1; start = 1'b0; start_s = 1'b0;
        set_flips(7'd0, 7'd0, 7'd0, 7'd0);
        repeat (3) @(negedge clk);
        check("reset_state", 32'({busy, done, pass, fail_mask, err_cnt, ffv, ffvec, A, B}), 32'd0);
        check("reset_state_sat", 32'({busy_s, done_s, pass_s, fail_mask_s, err_cnt_s, ffv_s, ffvec_s}), 32'd0);
        rst = 1'b0;

        // Correct library, XOR stuck at 0, NOT inverted.
        set_flips(7'd0, 7'd0, 7'd0, 7'd0);
        launch(t0); drain();
        set_flips(7'd0, 7'b0100000, 7'b0100000, 7'd0);
        launch(t0); drain();
        set_flips(7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000);
        launch(t0); drain();

        // Extra start pulses mid-run must not move completion.
        set_flips(7'd0, 7'd0, 7'b0000011, 7'd0);
        launch(t0);
        repeat (4) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        drain();

        // start held through done: one-cycle done, second run with cleared accumulators.
        set_flips(7'd0, 7'b0100000, 7'b0100000, 7'd0);
        @(negedge clk);
        start = 1'b1;
        t0 = cyc + 1;
        tb = t0 + RUN + 1;
        push_expect(t0);
        push_expect(tb);
        while (cyc < tb) @(negedge clk);
        check("held_done_pulse", 32'({done, busy}), 32'({1'b0, 1'b1}));
        check("held_rerun_clear", 32'({fail_mask, err_cnt, ffv}), 32'd0);
        start = 1'b0;
        drain();

        // Reset during vector 2 aborts everything, then a clean run.
        set_flips(7'b1000001, 7'd0, 7'd0, 7'd0);
        launch(t0);
        while (cyc < t0 + 2 * (S + 1) + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        q.delete();
        check("mid_reset", 32'({busy, done, pass, fail_mask, err_cnt, ffv, ffvec, A, B}), 32'd0);
        rst = 1'b0;
        set_flips(7'd0, 7'd0, 7'd0, 7'd0);
        launch(t0); drain();

        // Randomized fault masks, sometimes with a stray start pulse during the run.
        for (int r = 0; r < 20; r++) begin
            for (int v = 0; v < 4; v++)
                flip_a[v] = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
            launch(t0);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 8)) @(negedge clk);
                start = 1'b1; @(negedge clk); start = 1'b0;
            end
            drain();
        end

        // Narrow error counter saturates when every vector mismatches on every gate.
        @(negedge clk); start_s = 1'b1;
        @(negedge clk); start_s = 1'b0;
        for (int i = 0; i < 40 && !done_s; i++) @(negedge clk);
        check("sat_done", 32'({done_s, busy_s}), 32'({1'b1, 1'b0}));
        check("sat_err_cnt", 32'(err_cnt_s), 32'(3));
        check("sat_fail_mask", 32'(fail_mask_s), 32'(7'h7F));
        check("sat_summary", 32'({pass_s, ffv_s, ffvec_s}), 32'({1'b0, 1'b1, 2'b00}));

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_gate_mux_bist

// File: doc/gate_mux_bist.md
Name: gate_mux_bist

Overview:
Hardware stimulus-and-check engine for the 2x1-mux basic-gate library (AND, OR, NOR, NAND, NOT, XOR, XNOR). It drives the shared A/B inputs of the gate instances through all four input combinations and waits a programmable settle time after each one. It then compares the seven gate outputs against an internal golden model and reports a pass/fail summary. It replaces display-based checking with a synthesizable, self-checking block that can sit beside the gate library on silicon or FPGA.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..15; 0 is illegal (elaboration assertion).
ERR_W, 3, width of the mismatching-vector counter; the counter saturates at 2^ERR_W-1.

Ports:
clk  input  1  clock, all logic rising-edge.
rst  input  1  synchronous reset, active-high.
start  input  1  single-cycle or level request to begin a run; sampled only in IDLE.
A  output  1  stimulus bit A, shared by all gate instances.
B  output  1  stimulus bit B, shared by all gate instances.
resp  input  7  gate outputs: [0]AND [1]OR [2]NOR [3]NAND [4]NOT(A) [5]XOR [6]XNOR.
busy  output  1  high while a run is in progress.
done  output  1  sticky; high from the end of a run until the next accepted start or reset.
pass  output  1  valid when done=1; 1 iff fail_mask==0.
fail_mask  output  7  per-gate OR of mismatches over the run, same bit order as resp.
err_cnt  output  ERR_W  number of vectors with at least one mismatching bit; saturating.
first_fail_valid  output  1  set at the first mismatching vector of the run.
first_fail_vec  output  2  {A,B} of the first mismatching vector.

Behaviour:
- Reset values: state=IDLE, A=0, B=0, busy=0, done=0, pass=0, fail_mask=0, err_cnt=0, first_fail_valid=0, first_fail_vec=0.
- Reset mid-run aborts at the next edge; nothing is retained.
- FSM states: IDLE, SETTLE, CHECK.
- IDLE:
  - On start=1 at edge t0: clear fail_mask, err_cnt, first_fail_*, done and pass.
  - Load vec=0 and drive {A,B}=vec.
  - Load settle counter = SETTLE_CYCLES-1, set busy=1, go to SETTLE.
- SETTLE:
  - {A,B} is held stable.
  - The counter decrements each cycle; at 0 the FSM goes to CHECK, so SETTLE lasts exactly SETTLE_CYCLES cycles.
- CHECK (one cycle):
  - mism = resp ^ golden(vec); fail_mask |= mism.
  - If mism != 0: err_cnt += 1 (saturating). If first_fail_valid=0, set first_fail_valid=1 and first_fail_vec=vec.
  - If vec != 3: vec += 1, {A,B} updates on the same edge, reload the counter, go to SETTLE.
  - If vec == 3: go to IDLE with busy=0, done=1, pass=(final fail_mask==0), and {A,B} returning to 0.
- Latency: done rises at edge t0 + 4*(SETTLE_CYCLES+1).
- Golden model: AND=a&b, OR=a|b, NOR=~(a|b), NAND=~(a&b), NOT=~a, XOR=a^b, XNOR=~(a^b). Vector order is 00, 01, 10, 11, with A as the MSB.
- resp is sampled only in CHECK; X or glitches during SETTLE are ignored.
- start while busy is ignored and not queued.
- If start is held high through done, a new run begins on the first IDLE cycle. That edge clears done, so done is high for one cycle in this case.
- done, pass, fail_mask, err_cnt and first_fail_* hold their values in IDLE until the next accepted start.

Decomposition:
- Package gate_mux_bist_pkg:
  - FSM state enum.
  - Gate bit-index constants (AND_IDX..XNOR_IDX).
  - NUM_GATES=7 and NUM_VECS=4.
- Sub-module gate_golden_model: combinational 2-bit in, 7-bit expected out, instantiated once.
- Settle counter, vector counter, FSM and accumulators stay in gate_mux_bist.

Test Plan:
- Correct gate library connected, SETTLE_CYCLES=2, start pulse at t0 -> busy for 12 cycles; A,B step through 00,01,10,11; done=1 at t0+12; pass=1, fail_mask=7'h00, err_cnt=0, first_fail_valid=0.
- resp[5] (XOR) forced to 0 -> fail_mask=7'b0100000, err_cnt=2, first_fail_vec=2'b01, pass=0.
- resp[4] (NOT) inverted -> fail_mask=7'b0010000, err_cnt=4, first_fail_vec=2'b00, pass=0.
- ERR_W=2, resp forced to ~golden on all vectors -> err_cnt saturates at 3, fail_mask=7'h7F.
- rst=1 asserted during vector 2 -> next edge: busy=0, done=0, A=B=0, fail_mask=0, err_cnt=0. A following start runs a clean pass.
- start pulsed again mid-run -> ignored, completion time unchanged. start held high -> done high for exactly 1 cycle and a second run starts with counters cleared.
